ls_arbiter: RTL and testbench

Arbiter and sequencer for the SPU's single-ported 32 KB local store. Three requesters share one quadword port: DMA, the odd-pipe load/store unit, and instruction fetch. The block grants at most one access per cycle and drives a registered command onto the memory array. It then returns read data tagged with the originating requester after the fixed array latency. It sits between the odd-pipe load/store stage, the DMA engine, the fetch unit and the local-store array.

---
 rtl/spu_ls_pkg.sv | 29 ++
 rtl/ls_rd_tag_pipe.sv | 46 ++++
 rtl/ls_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ls_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spu_ls_pkg.sv
// Shared types and constants for the SPU local-store arbiter slice.
//   QW_ADDR_W   : quadword index width (32 KB / 16 B = 2048 entries)
//   QW_W        : quadword data width
//   ls_req_id_t : requester identity, also the encoding of rd_dest
//   sat_inc4    : 4-bit saturating increment used by the arbiter counters
package spu_ls_pkg;

  localparam int QW_ADDR_W = 11;
  localparam int QW_W      = 128;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_DMA  = 2'd1,
    REQ_LS   = 2'd2,
    REQ_IF   = 2'd3
  } ls_req_id_t;

  // Increment v by one, but never beyond lim.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    logic [3:0] res;
    if (v >= lim) begin
      res = lim;
    end else begin
      res = v + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ls_rd_tag_pipe.sv
// Read-return tag pipeline: carries {valid, dest} of each issued read for
// DEPTH cycles so the tag lines up with the array's read data.
// Ports:
//   clk      : clock
//   i_clr_n  : synchronous active-low clear (drops all in-flight tags)
//   i_valid  : tag valid entering the pipe
//   i_dest   : requester owning the read
//   o_valid  : tag valid leaving the pipe (registered)
//   o_dest   : requester leaving the pipe (registered, REQ_NONE when idle)
module ls_rd_tag_pipe
  import spu_ls_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic       clk,
  input  logic       i_clr_n,
  input  logic       i_valid,
  input  ls_req_id_t i_dest,
  output logic       o_valid,
  output ls_req_id_t o_dest
);

  logic [DEPTH-1:0] r_valid;
  ls_req_id_t       r_dest [DEPTH];

  // Shift register of read tags with synchronous clear.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_dest[k] <= REQ_NONE;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_dest[0]  <= i_dest;
      for (int k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_dest[k]  <= r_dest[k-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_dest  = r_dest[DEPTH-1];

endmodule

// File: rtl/ls_arbiter.sv
// Local-store port arbiter for DMA, load/store and instruction fetch.
// Grants at most one access per cycle, registers the chosen command onto the
// single-ported array and tags read data with its requester after MEM_LAT.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   dma_* / ls_* / if_*   : level-held requests and their grants
//   mem_en/we/addr/wdata  : registered array command
//   mem_rdata             : array read data
//   rd_valid/rd_dest      : returned read valid and owner (1 DMA, 2 LS, 3 IF)
//   rdata                 : returned read data (passes mem_rdata through)
module ls_arbiter
  import spu_ls_pkg::*;
#(
  parameter int MEM_LAT      = 6,
  parameter int DMA_MAX      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [0:QW_ADDR_W-1] dma_addr,
  input  logic [0:QW_W-1]      dma_wdata,
  output logic                 dma_gnt,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [0:QW_ADDR_W-1] ls_addr,
  input  logic [0:QW_W-1]      ls_wdata,
  output logic                 ls_gnt,
  input  logic                 if_req,
  input  logic [0:QW_ADDR_W-1] if_addr,
  output logic                 if_gnt,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [0:QW_ADDR_W-1] mem_addr,
  output logic [0:QW_W-1]      mem_wdata,
  input  logic [0:QW_W-1]      mem_rdata,
  output logic                 rd_valid,
  output logic [1:0]           rd_dest,
  output logic [0:QW_W-1]      rdata
);

  localparam logic [3:0] DMA_MAX_C = 4'(DMA_MAX);
  localparam logic [3:0] STARVE_C  = 4'(STARVE_LIMIT);

  logic [3:0]           r_dma_run;
  logic [3:0]           r_if_wait;
  logic [3:0]           w_dma_run_nxt;
  logic [3:0]           w_if_wait_nxt;
  logic                 w_dma_mask;
  logic                 w_if_promote;
  logic                 w_dma_gnt;
  logic                 w_ls_gnt;
  logic                 w_if_gnt;
  logic                 w_any_gnt;
  logic                 w_sel_we;
  logic [0:QW_ADDR_W-1] w_sel_addr;
  logic [0:QW_W-1]      w_sel_wdata;
  ls_req_id_t           w_sel_id;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [0:QW_ADDR_W-1] r_mem_addr;
  logic [0:QW_W-1]      r_mem_wdata;
  logic                 r_tag_valid;
  ls_req_id_t           r_tag_dest;
  logic                 w_pipe_valid;
  ls_req_id_t           w_pipe_dest;

  // The DMA cap only bites while someone else is waiting; a lone DMA stream
  // runs unthrottled.
  assign w_dma_mask   = (r_dma_run == DMA_MAX_C) && (ls_req || if_req);
  assign w_if_promote = if_req && (r_if_wait >= STARVE_C);

  // Priority select: promoted IF, then DMA (unless capped), LS, IF.
  always_comb begin
    w_dma_gnt = 1'b0;
    w_ls_gnt  = 1'b0;
    w_if_gnt  = 1'b0;
    if (!reset) begin
      w_dma_gnt = 1'b0;
    end else if (w_if_promote) begin
      w_if_gnt = 1'b1;
    end else if (dma_req && !w_dma_mask) begin
      w_dma_gnt = 1'b1;
    end else if (ls_req) begin
      w_ls_gnt = 1'b1;
    end else if (if_req) begin
      w_if_gnt = 1'b1;
    end else begin
      w_dma_gnt = 1'b0;
    end
  end

  assign w_any_gnt = w_dma_gnt || w_ls_gnt || w_if_gnt;

  // Command mux for the granted requester.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_id    = REQ_NONE;
    if (w_dma_gnt) begin
      w_sel_we    = dma_we;
      w_sel_addr  = dma_addr;
      w_sel_wdata = dma_wdata;
      w_sel_id    = REQ_DMA;
    end else if (w_ls_gnt) begin
      w_sel_we    = ls_we;
      w_sel_addr  = ls_addr;
      w_sel_wdata = ls_wdata;
      w_sel_id    = REQ_LS;
    end else if (w_if_gnt) begin
      w_sel_id    = REQ_IF;
      w_sel_addr  = if_addr;
    end else begin
      w_sel_id    = REQ_NONE;
    end
  end

  // Counter updates. dma_run saturates at DMA_MAX so the cap still applies
  // when another requester shows up after a long lone DMA burst.
  always_comb begin
    w_dma_run_nxt = 4'd0;
    w_if_wait_nxt = 4'd0;
    if (w_dma_gnt) begin
      w_dma_run_nxt = sat_inc4(r_dma_run, DMA_MAX_C);
    end else begin
      w_dma_run_nxt = 4'd0;
    end
    if (if_req && !w_if_gnt) begin
      w_if_wait_nxt = sat_inc4(r_if_wait, STARVE_C);
    end else begin
      w_if_wait_nxt = 4'd0;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dma_run <= 4'd0;
      r_if_wait <= 4'd0;
    end else begin
      r_dma_run <= w_dma_run_nxt;
      r_if_wait <= w_if_wait_nxt;
    end
  end

  // Array command register plus the read tag that travels with it; address
  // and write data hold when idle to avoid needless toggling on the array.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag_valid <= 1'b0;
      r_tag_dest  <= REQ_NONE;
    end else if (w_any_gnt) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= w_sel_we;
      r_mem_addr  <= w_sel_addr;
      r_mem_wdata <= w_sel_wdata;
      r_tag_valid <= !w_sel_we;
      r_tag_dest  <= w_sel_we ? REQ_NONE : w_sel_id;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_tag_valid <= 1'b0;
      r_tag_dest  <= REQ_NONE;
    end
  end

  // The tag leaves the command register at N+1 and spends MEM_LAT more
  // cycles in the pipe, meeting the array data at N+1+MEM_LAT.
  ls_rd_tag_pipe #(
    .DEPTH (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .i_clr_n (reset),
    .i_valid (r_tag_valid),
    .i_dest  (r_tag_dest),
    .o_valid (w_pipe_valid),
    .o_dest  (w_pipe_dest)
  );

  assign dma_gnt   = w_dma_gnt;
  assign ls_gnt    = w_ls_gnt;
  assign if_gnt    = w_if_gnt;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rd_valid  = w_pipe_valid;
  assign rd_dest   = w_pipe_dest;
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_ls_arbiter.sv
// Scoreboard bench for ls_arbiter: directed stimulus pushes expected read
// returns; a monitor pops and compares on every rd_valid. The bench also
// models the local-store array with MEM_LAT cycles of read latency.
module tb_ls_arbiter;
  localparam int MEM_LAT = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          dma_req, dma_we, ls_req, ls_we, if_req;
  logic [0:10]   dma_addr, ls_addr, if_addr;
  logic [0:127]  dma_wdata, ls_wdata;
  logic          dma_gnt, ls_gnt, if_gnt;
  logic          mem_en, mem_we;
  logic [0:10]   mem_addr;
  logic [0:127]  mem_wdata, mem_rdata, rdata;
  logic          rd_valid;
  logic [1:0]    rd_dest;

  int checks = 0;
  int errors = 0;
  int rdv_count = 0;
  logic [1:0]   exp_dest_q[$];
  logic [127:0] exp_data_q[$];

  logic [0:127] mem [0:2047];
  logic [0:127] rd_pipe [0:MEM_LAT-1];

  always #5 clk = ~clk;

  ls_arbiter #(.MEM_LAT(MEM_LAT), .DMA_MAX(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_dest(rd_dest), .rdata(rdata)
  );

  function automatic logic [0:127] pat(input int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  // Array model: a sampled read command appears on mem_rdata MEM_LAT cycles on.
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = pat(i);
    for (int k = 0; k < MEM_LAT; k++) rd_pipe[k] = '0;
    forever begin
      @(posedge clk);
      for (int k = MEM_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
      rd_pipe[0] <= '0;
      if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) rd_pipe[0] <= mem[mem_addr];
    end
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_gnt(input string name, input logic [2:0] exp);
    chk(name, {125'd0, dma_gnt, ls_gnt, if_gnt}, {125'd0, exp});
  endtask

  task automatic push_exp(input logic [1:0] d, input logic [0:127] data);
    exp_dest_q.push_back(d);
    exp_data_q.push_back(data);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_dest_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(exp_dest_q.size()), 128'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic drop_all();
    dma_req = 1'b0; ls_req = 1'b0; if_req = 1'b0;
  endtask

  // Monitor: one-hot grants every cycle, and scoreboard compare on rd_valid.
  initial begin
    logic [1:0]   d;
    logic [127:0] x;
    forever begin
      @(negedge clk);
      checks++;
      if ($countones({dma_gnt, ls_gnt, if_gnt}) > 1) begin
        errors++;
        $display("FAIL gnt_onehot actual=%b required=at most one", {dma_gnt, ls_gnt, if_gnt});
      end
      if (rd_valid === 1'b1) begin
        rdv_count++;
        if (exp_dest_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid actual=1 required=0 dest=%0d", rd_dest);
        end else begin
          d = exp_dest_q.pop_front();
          x = exp_data_q.pop_front();
          chk("sb_dest", {126'd0, rd_dest}, {126'd0, d});
          chk("sb_data", rdata, x);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  logic [2:0] p_dl [0:9]  = '{3'b100,3'b100,3'b100,3'b100,3'b010,3'b100,3'b100,3'b100,3'b100,3'b010};
  logic [2:0] p_di [0:9]  = '{3'b100,3'b100,3'b100,3'b100,3'b001,3'b100,3'b100,3'b100,3'b100,3'b001};
  logic [2:0] p_all [0:13] = '{3'b100,3'b100,3'b100,3'b100,3'b010,3'b100,3'b100,3'b100,3'b001,
                               3'b100,3'b100,3'b100,3'b100,3'b010};

  initial begin
    int pulses;
    reset = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    if_req = 1'b0; if_addr = '0;
    repeat (3) step();

    // Reset values, including no grant while a request is pending in reset.
    dma_req = 1'b1;
    @(negedge clk);
    chk_gnt("rst_gnt", 3'b000);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 11'd0);
    chk("rst_mem_wdata", mem_wdata, 128'd0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_dest", rd_dest, 2'd0);

    // Reset release with an LS read of index 5 in cycle 0.
    step();
    dma_req = 1'b0; reset = 1'b1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 11'd5;
    push_exp(2'd2, pat(5));
    @(negedge clk);
    chk_gnt("t1_gnt", 3'b010);
    step();
    ls_req = 1'b0;
    @(negedge clk);
    chk("t1_mem_en", mem_en, 1'b1);
    chk("t1_mem_we", mem_we, 1'b0);
    chk("t1_mem_addr", mem_addr, 11'd5);
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      chk("t1_rd_valid_time", rd_valid, (c == 7) ? 1'b1 : 1'b0);
    end
    chk("t1_rd_dest", rd_dest, 2'd2);
    drain("t1_drain");

    // LS store then load of the same index.
    pulses = rdv_count;
    step();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 11'd9; ls_wdata = {16{8'hA5}};
    @(negedge clk);
    chk_gnt("t2_wr_gnt", 3'b010);
    step();
    ls_we = 1'b0;
    push_exp(2'd2, {16{8'hA5}});
    @(negedge clk);
    chk_gnt("t2_rd_gnt", 3'b010);
    step();
    ls_req = 1'b0;
    drain("t2_drain");
    chk("t2_one_pulse", 128'(rdv_count - pulses), 128'd1);

    // DMA and LS streams (writes): DMA cap gives DDDDL DDDDL.
    step();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 11'd100; dma_wdata = pat(1000);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 11'd200; ls_wdata = pat(2000);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_gnt("t3_dma_ls", p_dl[c]);
      step();
    end
    drop_all();
    step();

    // DMA and IF streams: IF wins through the DMA cap.
    dma_req = 1'b1; if_req = 1'b1; if_addr = 11'd300;
    for (int c = 0; c < 10; c++) begin
      if (p_di[c] == 3'b001) push_exp(2'd3, pat(300));
      @(negedge clk);
      chk_gnt("t4_dma_if", p_di[c]);
      step();
    end
    drop_all();
    drain("t4_drain");

    // LS and IF streams: IF promoted after 8 denied cycles, twice.
    step();
    ls_req = 1'b1; if_req = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c == 8 || c == 17) push_exp(2'd3, pat(300));
      @(negedge clk);
      chk_gnt("t5_ls_if", (c == 8 || c == 17) ? 3'b001 : 3'b010);
      step();
    end
    drop_all();
    drain("t5_drain");

    // All three requesting: cap, then promotion, then dma_run restarts.
    step();
    dma_req = 1'b1; ls_req = 1'b1; if_req = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (p_all[c] == 3'b001) push_exp(2'd3, pat(300));
      @(negedge clk);
      chk_gnt("t6_all", p_all[c]);
      step();
    end
    drop_all();
    drain("t6_drain");

    // Three reads in flight, then one reset cycle: nothing returns.
    step();
    ls_req = 1'b1; ls_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ls_addr = 11'(20 + c);
      @(negedge clk);
      chk_gnt("t7_rd_gnt", 3'b010);
      step();
    end
    ls_req = 1'b0;
    step();
    step();
    reset = 1'b0; dma_req = 1'b1; dma_we = 1'b0;
    @(negedge clk);
    chk_gnt("t7_rst_gnt", 3'b000);
    step();
    reset = 1'b1; dma_req = 1'b0;
    @(negedge clk);
    chk_gnt("t7_post_gnt", 3'b000);
    chk("t7_mem_en", mem_en, 1'b0);
    chk("t7_mem_we", mem_we, 1'b0);
    chk("t7_mem_addr", mem_addr, 11'd0);
    chk("t7_mem_wdata", mem_wdata, 128'd0);
    chk("t7_rd_dest", rd_dest, 2'd0);
    for (int c = 0; c < 10; c++) begin
      chk("t7_no_rd_valid", rd_valid, 1'b0);
      @(negedge clk);
    end

    // Same-index DMA write and LS read: DMA first, LS returns DMA data.
    step();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 11'd40; dma_wdata = {16{8'h5A}};
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 11'd40;
    @(negedge clk);
    chk_gnt("t8_dma_first", 3'b100);
    step();
    dma_req = 1'b0;
    push_exp(2'd2, {16{8'h5A}});
    @(negedge clk);
    chk_gnt("t8_ls_next", 3'b010);
    step();
    ls_req = 1'b0;
    drain("t8_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
